// File: rtl/sort_host_pkg.sv
// rtl/sort_host_pkg.sv - shared types and sizes for the selection-sorter host controller
package sort_host_pkg;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int DW = 8;

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        GAP     = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        RD_ADDR = 3'd4,
        RD_W1   = 3'd5,
        RD_W2   = 3'd6,
        OUT     = 3'd7
    } state_e;

endpackage

// File: rtl/sort_host_if.sv
// rtl/sort_host_if.sv - byte streams and sorter bus seen by the sort host
interface sort_host_if;
    import sort_host_pkg::*;

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          s_start;
    logic [AW-1:0] s_addr;
    logic          s_wr;
    logic [DW-1:0] s_datain;
    logic [DW-1:0] s_dataout;
    logic          s_ready;

    modport master (
        input  in_valid, in_data, out_ready, s_dataout, s_ready,
        output in_ready, out_valid, out_data, s_start, s_addr, s_wr, s_datain
    );

    modport slave (
        output in_valid, in_data, out_ready, s_dataout, s_ready,
        input  in_ready, out_valid, out_data, s_start, s_addr, s_wr, s_datain
    );

endinterface

// File: rtl/sort_host.sv
// rtl/sort_host.sv - loads 8 bytes into the sorter, starts it, streams results back in address order
// Optional ordering checker (err port) built with SORT_HOST_CHECK_EN.
module sort_host
    import sort_host_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    sort_host_if.master bus,
    output logic       busy
`ifdef SORT_HOST_CHECK_EN
    ,
    output logic       err
`endif
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] k_q, k_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          hs_in, hs_out;

`ifdef SORT_HOST_CHECK_EN
    logic [DW-1:0] prev_q, prev_d;
    logic          err_q, err_d;
`endif

    assign hs_in  = (state_q == LOAD) && bus.in_valid;
    assign hs_out = (state_q == OUT) && bus.out_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            k_q        <= '0;
            out_data_q <= '0;
`ifdef SORT_HOST_CHECK_EN
            prev_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
`ifdef SORT_HOST_CHECK_EN
            prev_q     <= prev_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        out_data_d = out_data_q;
        unique case (state_q)
            LOAD: begin
                if (hs_in) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == LAST_IDX) state_d = GAP;
                end
            end
            // one idle cycle lets the sorter's registered write of the last byte land
            GAP:     state_d = START;
            START:   if (!bus.s_ready) state_d = WAIT;
            WAIT: begin
                if (bus.s_ready) begin
                    state_d = RD_ADDR;
                    k_d     = '0;
                end
            end
            RD_ADDR: state_d = RD_W1;
            RD_W1:   state_d = RD_W2;
            RD_W2: begin
                out_data_d = bus.s_dataout;
                state_d    = OUT;
            end
            OUT: begin
                if (hs_out) begin
                    k_d = k_q + AW'(1);
                    if (k_q == LAST_IDX) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

`ifdef SORT_HOST_CHECK_EN
    always_comb begin
        prev_d = prev_q;
        err_d  = err_q;
        if (hs_in && (cnt_q == '0)) err_d = 1'b0;
        if (hs_out) begin
            prev_d = out_data_q;
            if ((k_q != '0) && (out_data_q < prev_q)) err_d = 1'b1;
        end
    end

    assign err = err_q;
`endif

    always_comb begin
        bus.in_ready  = (state_q == LOAD);
        bus.out_valid = (state_q == OUT);
        bus.out_data  = out_data_q;
        bus.s_start   = (state_q == START);
        bus.s_wr      = hs_in;
        bus.s_datain  = hs_in ? bus.in_data : '0;
        busy          = (state_q != LOAD);
        bus.s_addr    = '0;
        unique case (state_q)
            LOAD:                 bus.s_addr = cnt_q;
            RD_ADDR, RD_W1, RD_W2: bus.s_addr = k_q;
            default:              bus.s_addr = '0;
        endcase
    end

endmodule

// File: tb/tb_sort_host.sv
// tb/tb_sort_host.sv - scoreboard bench for sort_host with a behavioural selection-sorter beside it
module tb_sort_host;
    import sort_host_pkg::*;

    typedef logic [7:0] b8_t [8];

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic busy;
`ifdef SORT_HOST_CHECK_EN
    logic err;
`endif

    sort_host_if bus();

    sort_host dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.master),
        .busy (busy)
`ifdef SORT_HOST_CHECK_EN
        ,
        .err  (err)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;
    logic [7:0] sbq[$];
    bit force_mode = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic b8_t sort8(input b8_t a);
        b8_t t;
        logic [7:0] x;
        t = a;
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7 - i; j++)
                if (t[j] > t[j+1]) begin
                    x = t[j]; t[j] = t[j+1]; t[j+1] = x;
                end
        return t;
    endfunction

    // readback pattern used to provoke an ordering error: 1,2,0,3,4,5,6,7
    function automatic logic [7:0] ftab(input logic [2:0] a);
        if (a == 3'd0) return 8'd1;
        if (a == 3'd1) return 8'd2;
        if (a == 3'd2) return 8'd0;
        return {5'd0, a};
    endfunction

    // sorter: registered write, 2-cycle read latency, s_ready low while sorting
    b8_t mem;
    logic [7:0] rd1, rd2;
    logic sready;
    int scnt;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sready <= 1'b1;
            scnt   <= 0;
            rd1    <= '0;
            rd2    <= '0;
        end else begin
            rd1 <= force_mode ? ftab(bus.s_addr) : mem[bus.s_addr];
            rd2 <= rd1;
            if (bus.s_wr) mem[bus.s_addr] <= bus.s_datain;
            if (bus.s_start && sready) begin
                sready <= 1'b0;
                scnt   <= 6;
            end else if (!sready) begin
                if (scnt == 0) begin
                    mem    <= sort8(mem);
                    sready <= 1'b1;
                end else begin
                    scnt <= scnt - 1;
                end
            end
        end
    end
    assign bus.s_dataout = rd2;
    assign bus.s_ready   = sready;

    int cyc = 0;
    int viol = 0;
    logic start_prev = 1'b0;
    logic [2:0] wr_addr_q[$];
    int wr_cyc_q[$];
    int start_cyc_q[$];
    always @(negedge clk) begin
        cyc++;
        if (bus.s_wr) begin
            wr_addr_q.push_back(bus.s_addr);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.s_start && !start_prev) start_cyc_q.push_back(cyc);
        start_prev = bus.s_start;
        if (bus.s_start && bus.s_wr) viol++;
        if (busy && (bus.s_wr || bus.in_ready)) viol++;
        if (!busy && bus.out_valid) viol++;
    end

    task automatic load_batch(input b8_t b, input bit sparse);
        int i, g;
        logic acc;
        b8_t s;
        i = 0;
        g = 0;
        while (i < 8 && g < 100) begin
            bus.in_valid = !(sparse && g[0]);
            bus.in_data  = b[i];
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            g++;
        end
        bus.in_valid = 1'b0;
        check_eq("load_done", i, 8);
        if (force_mode) begin
            for (int k = 0; k < 8; k++) sbq.push_back(ftab(3'(k)));
        end else begin
            s = sort8(b);
            for (int k = 0; k < 8; k++) sbq.push_back(s[k]);
        end
    endtask

    task automatic drain(input int stall_k, input bit noise);
        int g;
        logic [7:0] exp;
        for (int j = 0; j < 8; j++) begin
            g = 0;
            @(negedge clk);
            while (!bus.out_valid && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) begin
                check_eq("out_timeout", g, 0);
                return;
            end
            exp = (sbq.size() > 0) ? sbq.pop_front() : 8'hxx;
            check_eq("out_data", bus.out_data, exp);
            if (j == stall_k) begin
                repeat (5) begin
                    @(negedge clk);
                    check_eq("out_hold", {bus.out_valid, bus.out_data}, {1'b1, exp});
                end
            end
            if (noise && j == 7) bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
`ifdef SORT_HOST_CHECK_EN
            check_eq("err_after_hs", err, (force_mode && j >= 2) ? 1 : 0);
`endif
        end
    endtask

    initial begin
        b8_t b;
        int base_w, base_s, g;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_outs", {bus.out_valid, bus.s_start, bus.s_wr, bus.s_addr, bus.s_datain, busy, bus.out_data}, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
`ifdef SORT_HOST_CHECK_EN
        check_eq("rst_err", err, 0);
`endif
        @(posedge clk); #1;
        nrst = 1'b1;

        b = '{8'd5, 8'd3, 8'd7, 8'd0, 8'd6, 8'd1, 8'd4, 8'd2};
        load_batch(b, 1'b0);
        drain(-1, 1'b0);

        // in_valid held high through the non-LOAD states must be ignored
        b = '{default: 8'h80};
        load_batch(b, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        drain(-1, 1'b1);

        b = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        load_batch(b, 1'b0);
        drain(3, 1'b0);

        base_w = wr_addr_q.size();
        base_s = start_cyc_q.size();
        b = '{8'd40, 8'd10, 8'd30, 8'd20, 8'd70, 8'd50, 8'd60, 8'd0};
        load_batch(b, 1'b1);
        drain(-1, 1'b0);
        check_eq("wr_pulses", wr_addr_q.size() - base_w, 8);
        if (wr_addr_q.size() - base_w == 8 && start_cyc_q.size() > base_s) begin
            for (int i = 0; i < 8; i++) check_eq("wr_addr", wr_addr_q[base_w + i], i);
            check_eq("gap_cycles", start_cyc_q[base_s] - wr_cyc_q[base_w + 7], 2);
        end else begin
            check_eq("start_seen", start_cyc_q.size() - base_s, 1);
        end

        b = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88};
        load_batch(b, 1'b0);
        g = 0;
        while (!bus.s_start && g < 50) begin @(negedge clk); g++; end
        while (bus.s_start && g < 50) begin @(negedge clk); g++; end
        check_eq("reach_wait", (g < 50) && busy, 1);
        @(posedge clk); #1;
        nrst = 1'b0;
        sbq.delete();
        @(negedge clk);
        check_eq("midrst_outs", {bus.out_valid, bus.s_start, bus.s_wr, bus.s_addr, bus.s_datain, busy, bus.out_data}, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        b = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
        load_batch(b, 1'b0);
        drain(-1, 1'b0);

`ifdef SORT_HOST_CHECK_EN
        force_mode = 1'b1;
        b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_batch(b, 1'b0);
        drain(-1, 1'b0);
        force_mode = 1'b0;
        load_batch(b, 1'b0);
        check_eq("err_cleared", err, 0);
        drain(-1, 1'b0);
`endif

        check_eq("invariants", viol, 0);
        check_eq("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
